// File: rtl/avalon_acc_master.sv
// Avalon-MM initiator for the float accumulator slave: buffers operands,
// then writes the init value, streams the operands and reads back the sum.
module avalon_acc_master #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic [31:0] init_value,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    output logic        avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, INIT_WR, DATA_WR, RD, FIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d, rem_q, rem_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [31:0]   init_q, init_d, result_q, result_d, wdata_q, wdata_d;
    logic          in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
    logic          error_q, error_d, write_q, write_d, read_q, read_d;
    logic          addr_q, addr_d;
    logic          push;

    always_comb begin
        push       = in_valid && in_ready_q;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rem_d      = rem_q;
        stall_d    = stall_q;
        init_d     = init_q;
        result_d   = result_q;
        error_d    = error_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    init_d  = init_value;
                    rem_d   = count_d;
                    error_d = 1'b0;
                    stall_d = '0;
                    state_d = INIT_WR;
                end
            end
            INIT_WR, DATA_WR, RD: begin
                if (!avm_waitrequest) begin
                    stall_d = '0;
                    if (state_q == INIT_WR) begin
                        state_d = (rem_q != '0) ? DATA_WR : RD;
                    end else if (state_q == DATA_WR) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                        rem_d    = rem_q - 1'b1;
                        if (rem_q == (AW+1)'(1)) state_d = RD;
                    end else begin
                        result_d = avm_readdata;
                        state_d  = FIN;
                    end
                end else if (stall_q == SW'(TIMEOUT - 1)) begin
                    // Abandon the sequence and drop whatever is still queued
                    error_d  = 1'b1;
                    rd_ptr_d = wr_ptr_q;
                    count_d  = '0;
                    rem_d    = '0;
                    stall_d  = '0;
                    state_d  = FIN;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus and status outputs are registered from the next state
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        write_d    = (state_d == INIT_WR) || (state_d == DATA_WR);
        read_d     = (state_d == RD);
        addr_d     = (state_d == INIT_WR) || (state_d == RD);
        in_ready_d = (state_d == IDLE) && (count_d < (AW+1)'(DEPTH));
        if (state_d == INIT_WR)      wdata_d = init_d;
        else if (state_d == DATA_WR) wdata_d = mem_q[rd_ptr_d];
        else                         wdata_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            stall_q    <= '0;
            init_q     <= '0;
            result_q   <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            stall_q    <= stall_d;
            init_q     <= init_d;
            result_q   <= result_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            write_q    <= write_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= in_data;
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign result        = result_q;
    assign avm_address   = addr_q;
    assign avm_write     = write_q;
    assign avm_read      = read_q;
    assign avm_writedata = wdata_q;

endmodule
